// File: rtl/load_store_unit_if.sv
// Bundle between the execute stage, the load/store unit and the data memory.
// The slave modport is the unit's view; the master modport is the view of
// whatever drives requests and models the memory.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Request side
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0] req_write_data;
    // Response side
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_read_data;
    logic                  resp_error;
    // Data memory side
    logic                  memory_we;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic [DATA_WIDTH-1:0] memory_write_data;
    logic [DATA_WIDTH-1:0] memory_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address,
               req_write_data, memory_read_data,
        output req_ready, resp_valid, resp_read_data, resp_error,
               memory_we, memory_address, memory_write_data
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address,
               req_write_data, memory_read_data,
        input  req_ready, resp_valid, resp_read_data, resp_error,
               memory_we, memory_address, memory_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage requests into word accesses on a
// word-addressed memory with combinational read and clocked write.
// Sub-word loads are lane-selected and extended; sub-word stores are done as
// a read-modify-write. Misaligned or illegal-size requests never reach memory
// and complete with resp_error instead.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_STORE,
        ST_RESP
    } state_t;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the target byte/halfword lane of a memory word with store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [15:0] data,
        input logic [1:0]  lo,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = word;
        if (size == 2'b00) begin
            r[{lo, 3'b000} +: 8] = data[7:0];
        end else begin
            r[{lo[1], 4'b0000} +: 16] = data;
        end
        return r;
    endfunction

    state_t                state_q,     state_d;
    logic [1:0]            addr_lo_q,   addr_lo_d;
    logic [1:0]            size_q,      size_d;
    logic                  uns_q,       uns_d;
    logic [15:0]           wdata_q,     wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q,    mem_we_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q,  resp_err_d;
    logic                  req_ready_q, req_ready_d;

    logic                  accept;
    logic                  req_bad;
    logic [ADDR_WIDTH-1:0] req_word_addr;

    // Request decode: acceptance, legality check and word-aligned address.
    always_comb begin
        accept        = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;
        req_bad       = (bus.req_size == 2'b11)
                     || ((bus.req_size == 2'b01) && bus.req_address[0])
                     || ((bus.req_size == 2'b10) && (bus.req_address[1:0] != 2'b00));
        req_word_addr = {bus.req_address[ADDR_WIDTH-1:2], 2'b00};
    end

    // Next-state and next-output logic; every output is registered, so each
    // value is computed here for the state being entered.
    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_err_d   = 1'b0;
        req_ready_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_lo_d = bus.req_address[1:0];
                    size_d    = bus.req_size;
                    uns_d     = bus.req_unsigned;
                    wdata_d   = bus.req_write_data[15:0];
                    if (req_bad) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!bus.req_write) begin
                        state_d    = ST_LOAD;
                        mem_addr_d = req_word_addr;
                    end else if (bus.req_size == 2'b10) begin
                        state_d     = ST_STORE;
                        mem_addr_d  = req_word_addr;
                        mem_wdata_d = bus.req_write_data;
                        mem_we_d    = 1'b1;
                    end else begin
                        state_d    = ST_MERGE;
                        mem_addr_d = req_word_addr;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = load_extend(bus.memory_read_data, addr_lo_q, size_q, uns_q);
            end
            ST_MERGE: begin
                state_d     = ST_STORE;
                mem_addr_d  = mem_addr_q;
                mem_wdata_d = store_merge(bus.memory_read_data, wdata_q, addr_lo_q, size_q);
                mem_we_d    = 1'b1;
            end
            ST_STORE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset returns to an idle, ready unit.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_lo_q    <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            req_ready_q  <= req_ready_d;
        end
    end

    // Reset in the STORE cycle must cancel the write at the closing edge.
    assign bus.memory_we         = mem_we_q & ~reset;
    assign bus.memory_address    = mem_addr_q;
    assign bus.memory_write_data = mem_wdata_q;
    assign bus.req_ready         = req_ready_q;
    assign bus.resp_valid        = resp_valid_q;
    assign bus.resp_read_data    = resp_data_q;
    assign bus.resp_error        = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory model on the bus, a byte-level
// reference model, a table of directed transactions, reset/back-to-back
// sequences and a randomized run.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Data memory: combinational read, write on the clock edge.
    logic [31:0] mem [0:255];
    logic        mem_init = 1'b1;
    assign bus.memory_read_data = mem[bus.memory_address[9:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[0] <= 32'd100;
            mem[1] <= 32'd200;
        end else if (bus.memory_we) begin
            mem[bus.memory_address[9:2]] <= bus.memory_write_data;
        end
    end

    // Reference model: memory as individual bytes.
    logic [7:0] rb [0:1023];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int widx);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 4; i++) w = w + (32'(rb[widx*4 + i]) << (8*i));
        return w;
    endfunction

    task automatic ref_tx(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] data, output logic err,
                          output int lat, output int we);
        int     nb;
        longint v;
        int     a;
        a    = int'(addr);
        nb   = 1 << size;
        err  = (size == 2'd3) || (size != 2'd0 && (a % nb) != 0);
        data = 32'd0;
        we   = 0;
        if (err) begin
            lat = 1;
        end else if (!wr) begin
            v = 0;
            for (int i = 0; i < nb; i++) v = v + (longint'(rb[a + i]) << (8*i));
            if (!uns && nb < 4 && v >= (longint'(1) << (8*nb - 1)))
                v = v - (longint'(1) << (8*nb));
            data = v[31:0];
            lat  = 2;
        end else begin
            for (int i = 0; i < nb; i++) rb[a + i] = 8'((wdata >> (8*i)) & 32'hFF);
            lat = (nb == 4) ? 2 : 3;
            we  = 1;
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_size       = 2'd0;
        bus.req_unsigned   = 1'b0;
        bus.req_address    = 32'd0;
        bus.req_write_data = 32'd0;
    endtask

    // One transaction: wait for ready, present for one edge, then watch
    // until resp_valid, reporting latency and memory_we cycles seen.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] data, output logic err,
                          output int lat, output int wes);
        int w;
        data = 32'hXXXXXXXX;
        err  = 1'bx;
        lat  = 0;
        wes  = 0;
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        bus.req_write      = wr;
        bus.req_size       = size;
        bus.req_unsigned   = uns;
        bus.req_address    = addr;
        bus.req_write_data = wdata;
        bus.req_valid      = 1'b1;
        @(posedge clk);
        #1 idle_inputs();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.memory_we) wes++;
            if (bus.resp_valid) begin
                data = bus.resp_read_data;
                err  = bus.resp_error;
                lat  = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    vec_t vecs [0:14];

    initial begin
        logic [31:0] d, md;
        logic        e, me;
        int          l, wes, ml, mwe;
        int          nresp, idx;
        logic [31:0] got [0:2];
        logic [31:0] b2b_addr [0:2];
        logic [1:0]  b2b_size [0:2];
        logic [31:0] b2b_exp  [0:2];

        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h4, 32'h0,        32'd200,       1'b0, 2, 0};
        vecs[1]  = '{1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0,         1'b0, 2, 1};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'hB, 32'h0,        32'hFFFFFFDE,  1'b0, 2, 0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'hB, 32'h0,        32'h000000DE,  1'b0, 2, 0};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h9, 32'h55,       32'h0,         1'b0, 3, 1};
        vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h8, 32'h0,        32'h000055EF,  1'b0, 2, 0};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0,        32'hDEAD55EF,  1'b0, 2, 0};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h3, 32'h0,        32'h0,         1'b1, 1, 0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h6, 32'h12345678, 32'h0,         1'b1, 1, 0};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0,        32'h0,         1'b1, 1, 0};
        vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h0, 32'hFF,       32'h0,         1'b1, 1, 0};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0,        32'd100,       1'b0, 2, 0};
        vecs[12] = '{1'b0, 2'd1, 1'b0, 32'hA, 32'h0,        32'hFFFFDEAD,  1'b0, 2, 0};
        vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h2, 32'hABCD1234, 32'h0,         1'b0, 3, 1};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h0, 32'h0,        32'h12340064,  1'b0, 2, 0};

        for (int i = 0; i < 1024; i++) rb[i] = 8'd0;
        rb[0] = 8'd100;
        rb[4] = 8'd200;

        idle_inputs();
        // A request presented during reset must be ignored.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'd2;
        repeat (3) @(negedge clk);
        idle_inputs();
        mem_init = 1'b0;
        rst      = 1'b0;
        check("reset_ready",      32'(bus.req_ready),    32'd1);
        check("reset_resp_valid", 32'(bus.resp_valid),   32'd0);
        check("reset_resp_error", 32'(bus.resp_error),   32'd0);
        check("reset_resp_data",  bus.resp_read_data,    32'd0);
        check("reset_mem_we",     32'(bus.memory_we),    32'd0);
        check("reset_mem_addr",   bus.memory_address,    32'd0);
        check("reset_mem_wdata",  bus.memory_write_data, 32'd0);
        check("reset_word0",      mem[0],                32'd100);

        // Reset during the MERGE cycle of a byte store to 0x0.
        bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_address = 32'h0;
        bus.req_write_data = 32'hAA; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("merge_rst_ready",  32'(bus.req_ready),  32'd1);
        check("merge_rst_valid",  32'(bus.resp_valid), 32'd0);
        check("merge_rst_addr",   bus.memory_address,  32'd0);
        wes = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.memory_we || bus.resp_valid) wes++;
        end
        check("merge_rst_no_activity", 32'(wes), 32'd0);
        check("merge_rst_word0", mem[0], 32'd100);

        // Reset during the STORE cycle of a byte store: the write is cancelled.
        bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_address = 32'h1;
        bus.req_write_data = 32'h77; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("store_rst_we_low", 32'(bus.memory_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("store_rst_word0", mem[0], 32'd100);

        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, d, e, l, wes);
        check("after_rst_load_data", d, 32'd100);
        check("after_rst_load_lat",  32'(l), 32'd2);

        // Back-to-back: req_valid held high across three loads.
        b2b_addr[0] = 32'h4; b2b_size[0] = 2'd2; b2b_exp[0] = 32'd200;
        b2b_addr[1] = 32'h0; b2b_size[1] = 2'd2; b2b_exp[1] = 32'd100;
        b2b_addr[2] = 32'h4; b2b_size[2] = 2'd0; b2b_exp[2] = 32'hFFFFFFC8;
        idx = 0; nresp = 0;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (nresp < 3) got[nresp] = bus.resp_read_data;
                nresp++;
            end
            if (idx < 3) begin
                bus.req_write   = 1'b0;
                bus.req_unsigned = 1'b0;
                bus.req_address = b2b_addr[idx];
                bus.req_size    = b2b_size[idx];
                bus.req_valid   = 1'b1;
                if (bus.req_ready) idx++;
            end else begin
                idle_inputs();
            end
        end
        check("b2b_accepted", 32'(idx),   32'd3);
        check("b2b_resp_cnt", 32'(nresp), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < nresp) check($sformatf("b2b_data%0d", i), got[i], b2b_exp[i]);

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            ref_tx(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   md, me, ml, mwe);
            do_req(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   d, e, l, wes);
            check($sformatf("vec%0d_data", i), d,       vecs[i].exp_data);
            check($sformatf("vec%0d_err", i),  32'(e),  32'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i),  32'(l),  32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_we", i),   32'(wes), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_mem", i),  mem[vecs[i].addr[9:2]],
                  ref_word(int'(vecs[i].addr[9:2])));
        end
        check("err_word1_unchanged", mem[1], 32'd200);

        // Randomized transactions against the byte-level model.
        for (int i = 0; i < 300; i++) begin
            logic        wr, uns;
            logic [1:0]  size;
            logic [31:0] addr, wdata;
            wr    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = 32'($urandom_range(0, 63));
            wdata = $urandom;
            if (size != 2'd3 && $urandom_range(0, 3) != 0)
                addr = addr & ~((32'd1 << size) - 32'd1);
            ref_tx(wr, size, uns, addr, wdata, md, me, ml, mwe);
            do_req(wr, size, uns, addr, wdata, d, e, l, wes);
            check($sformatf("rnd%0d_data", i), d,        md);
            check($sformatf("rnd%0d_err", i),  32'(e),   32'(me));
            check($sformatf("rnd%0d_lat", i),  32'(l),   32'(ml));
            check($sformatf("rnd%0d_we", i),   32'(wes), 32'(mwe));
            check($sformatf("rnd%0d_mem", i),  mem[addr[9:2]], ref_word(int'(addr[9:2])));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
